// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side master for the 32-bit ALU datapath.
// Accepts one request at a time, drives registered operands/controls to the
// ALU, captures the combinational ALU result and returns it with status flags.
// A 32-bit accumulator lets chained operations reuse the previous result as A.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_shamt,
    input  logic        req_use_acc,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_zero,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_c_0,
    output logic        alu_const_var,
    output logic        alu_shift_direction,
    output logic [1:0]  alu_function_class,
    output logic [1:0]  alu_logic_function,
    output logic [4:0]  alu_const_amount,
    input  logic [31:0] alu_s
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLT  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_SLLV = 4'h7;
    localparam logic [3:0] OP_SRLV = 4'h8;
    localparam logic [3:0] OP_SLL  = 4'h9;
    localparam logic [3:0] OP_SRL  = 4'hA;

    localparam logic [1:0] FC_SHIFT = 2'b00;
    localparam logic [1:0] FC_SLT   = 2'b01;
    localparam logic [1:0] FC_ARITH = 2'b10;
    localparam logic [1:0] FC_LOGIC = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic        illegal_q, illegal_d;

    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic        alu_c0_q, alu_c0_d;
    logic        alu_cv_q, alu_cv_d;
    logic        alu_dir_q, alu_dir_d;
    logic [1:0]  alu_fc_q, alu_fc_d;
    logic [1:0]  alu_lf_q, alu_lf_d;
    logic [4:0]  alu_ca_q, alu_ca_d;

    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_zero_q, rsp_zero_d;

    logic        dec_illegal;
    logic        dec_c0;
    logic        dec_cv;
    logic        dec_dir;
    logic [1:0]  dec_fc;
    logic [1:0]  dec_lf;
    logic [4:0]  dec_ca;

    // Translate the request opcode into ALU control fields; unused fields stay 0.
    always_comb begin
        dec_illegal = 1'b0;
        dec_c0      = 1'b0;
        dec_cv      = 1'b0;
        dec_dir     = 1'b0;
        dec_fc      = FC_SHIFT;
        dec_lf      = 2'b00;
        dec_ca      = 5'd0;
        case (req_op)
            OP_ADD: begin
                dec_fc = FC_ARITH;
            end
            OP_SUB: begin
                dec_fc = FC_ARITH;
                dec_c0 = 1'b1;
            end
            OP_SLT: begin
                dec_fc = FC_SLT;
                dec_c0 = 1'b1;
            end
            OP_AND: begin
                dec_fc = FC_LOGIC;
                dec_lf = 2'b00;
            end
            OP_OR: begin
                dec_fc = FC_LOGIC;
                dec_lf = 2'b01;
            end
            OP_XOR: begin
                dec_fc = FC_LOGIC;
                dec_lf = 2'b10;
            end
            OP_NOR: begin
                dec_fc = FC_LOGIC;
                dec_lf = 2'b11;
            end
            OP_SLLV: begin
                dec_fc  = FC_SHIFT;
                dec_dir = 1'b1;
                dec_cv  = 1'b1;
            end
            OP_SRLV: begin
                dec_fc  = FC_SHIFT;
                dec_dir = 1'b0;
                dec_cv  = 1'b1;
            end
            OP_SLL: begin
                dec_fc  = FC_SHIFT;
                dec_dir = 1'b1;
                dec_ca  = req_shamt;
            end
            OP_SRL: begin
                dec_fc  = FC_SHIFT;
                dec_dir = 1'b0;
                dec_ca  = req_shamt;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Sequencer next state: latch the request in IDLE, capture the ALU result in ISSUE, wait for consume in RESP.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        illegal_d  = illegal_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_c0_d   = alu_c0_q;
        alu_cv_d   = alu_cv_q;
        alu_dir_d  = alu_dir_q;
        alu_fc_d   = alu_fc_q;
        alu_lf_d   = alu_lf_q;
        alu_ca_d   = alu_ca_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_zero_d = rsp_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d   = ST_ISSUE;
                    illegal_d = dec_illegal;
                    if (dec_illegal) begin
                        alu_a_d   = 32'd0;
                        alu_b_d   = 32'd0;
                        alu_c0_d  = 1'b0;
                        alu_cv_d  = 1'b0;
                        alu_dir_d = 1'b0;
                        alu_fc_d  = 2'b00;
                        alu_lf_d  = 2'b00;
                        alu_ca_d  = 5'd0;
                    end else begin
                        alu_a_d   = req_use_acc ? acc_q : req_a;
                        alu_b_d   = req_b;
                        alu_c0_d  = dec_c0;
                        alu_cv_d  = dec_cv;
                        alu_dir_d = dec_dir;
                        alu_fc_d  = dec_fc;
                        alu_lf_d  = dec_lf;
                        alu_ca_d  = dec_ca;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
                if (illegal_q) begin
                    rsp_data_d = 32'd0;
                    rsp_err_d  = 1'b1;
                    rsp_zero_d = 1'b1;
                end else begin
                    rsp_data_d = alu_s;
                    rsp_err_d  = 1'b0;
                    rsp_zero_d = (alu_s == 32'd0);
                    acc_d      = alu_s;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, accumulator, ALU drive and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= 32'd0;
            illegal_q  <= 1'b0;
            alu_a_q    <= 32'd0;
            alu_b_q    <= 32'd0;
            alu_c0_q   <= 1'b0;
            alu_cv_q   <= 1'b0;
            alu_dir_q  <= 1'b0;
            alu_fc_q   <= 2'b00;
            alu_lf_q   <= 2'b00;
            alu_ca_q   <= 5'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            illegal_q  <= illegal_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_c0_q   <= alu_c0_d;
            alu_cv_q   <= alu_cv_d;
            alu_dir_q  <= alu_dir_d;
            alu_fc_q   <= alu_fc_d;
            alu_lf_q   <= alu_lf_d;
            alu_ca_q   <= alu_ca_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    // req_ready is masked by reset so it reads 0 while reset is held even though the state is already IDLE.
    assign req_ready           = (state_q == ST_IDLE) && !reset;
    assign rsp_valid           = (state_q == ST_RESP);
    assign rsp_data            = rsp_data_q;
    assign rsp_err             = rsp_err_q;
    assign rsp_zero            = rsp_zero_q;
    assign alu_a               = alu_a_q;
    assign alu_b               = alu_b_q;
    assign alu_c_0             = alu_c0_q;
    assign alu_const_var       = alu_cv_q;
    assign alu_shift_direction = alu_dir_q;
    assign alu_function_class  = alu_fc_q;
    assign alu_logic_function  = alu_lf_q;
    assign alu_const_amount    = alu_ca_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vector table, hand-written reset/backpressure
// sequences and randomized operations against an opcode-level reference model.
module tb_alu_op_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_shamt;
    logic        req_use_acc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_zero;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_c_0;
    logic        alu_const_var;
    logic        alu_shift_direction;
    logic [1:0]  alu_function_class;
    logic [1:0]  alu_logic_function;
    logic [4:0]  alu_const_amount;
    logic [31:0] alu_s;

    int          n_cmp;
    int          n_mis;
    logic [31:0] model_acc;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        ua;
        int          hold;
        logic        early;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];

    alu_op_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_op              (req_op),
        .req_a               (req_a),
        .req_b               (req_b),
        .req_shamt           (req_shamt),
        .req_use_acc         (req_use_acc),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_data            (rsp_data),
        .rsp_err             (rsp_err),
        .rsp_zero            (rsp_zero),
        .alu_a               (alu_a),
        .alu_b               (alu_b),
        .alu_c_0             (alu_c_0),
        .alu_const_var       (alu_const_var),
        .alu_shift_direction (alu_shift_direction),
        .alu_function_class  (alu_function_class),
        .alu_logic_function  (alu_logic_function),
        .alu_const_amount    (alu_const_amount),
        .alu_s               (alu_s)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model of the external combinational ALU.
    logic [4:0]  alu_amt;
    logic [31:0] alu_diff;
    always_comb begin
        alu_s    = 32'd0;
        alu_amt  = alu_const_var ? alu_a[4:0] : alu_const_amount;
        alu_diff = alu_a - alu_b;
        case (alu_function_class)
            2'b00: alu_s = alu_shift_direction ? (alu_b << alu_amt) : (alu_b >> alu_amt);
            2'b01: alu_s = {31'd0, alu_diff[31]};
            2'b10: alu_s = alu_c_0 ? alu_diff : (alu_a + alu_b);
            default: begin
                case (alu_logic_function)
                    2'b00:   alu_s = alu_a & alu_b;
                    2'b01:   alu_s = alu_a | alu_b;
                    2'b10:   alu_s = alu_a ^ alu_b;
                    default: alu_s = ~(alu_a | alu_b);
                endcase
            end
        endcase
    end

    // Safety net so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Opcode-level reference: what each operation should return for the effective operands.
    task automatic refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh, output logic [31:0] data, output logic err);
        logic [31:0] diff;
        diff = a - b;
        err  = 1'b0;
        data = 32'd0;
        case (op)
            4'h0: data = a + b;
            4'h1: data = diff;
            4'h2: data = {31'd0, diff[31]};
            4'h3: data = a & b;
            4'h4: data = a | b;
            4'h5: data = a ^ b;
            4'h6: data = ~(a | b);
            4'h7: data = b << a[4:0];
            4'h8: data = b >> a[4:0];
            4'h9: data = b << sh;
            4'hA: data = b >> sh;
            default: err = 1'b1;
        endcase
    endtask

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request through the full handshake and check every phase against the expectation.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic ua, input int hold,
                                 input logic early, input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] eff_a;
        int          waited;
        eff_a  = ua ? model_acc : a;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_op      = op;
        req_a       = a;
        req_b       = b;
        req_shamt   = sh;
        req_use_acc = ua;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_op      = 4'($urandom);
        req_a       = $urandom;
        req_b       = $urandom;
        req_shamt   = 5'($urandom);
        req_use_acc = 1'($urandom);
        checkOutput("alu_a_issue", alu_a, exp_err ? 32'd0 : eff_a);
        checkOutput("alu_b_issue", alu_b, exp_err ? 32'd0 : b);
        checkOutput("req_ready_issue", 32'(req_ready), 32'd0);
        checkOutput("rsp_valid_issue", 32'(rsp_valid), 32'd0);
        rsp_ready = early;
        @(posedge clk);
        #1;
        checkOutput("rsp_valid_resp", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_data", rsp_data, exp_data);
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
        checkOutput("rsp_zero", 32'(rsp_zero), 32'(exp_data == 32'd0));
        if (hold > 0 || !early) begin
            rsp_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                checkOutput("rsp_valid_hold", 32'(rsp_valid), 32'd1);
                checkOutput("rsp_data_hold", rsp_data, exp_data);
                checkOutput("req_ready_hold", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_done", 32'(rsp_valid), 32'd0);
        checkOutput("req_ready_done", 32'(req_ready), 32'd1);
        if (!exp_err) begin
            model_acc = exp_data;
        end
    endtask

    // Main test sequence: reset, directed table, reset-in-ISSUE, then random operations.
    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [4:0]  r_sh;
        logic        r_ua;
        logic [31:0] r_data;
        logic        r_err;

        n_cmp       = 0;
        n_mis       = 0;
        model_acc   = 32'd0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_op      = 4'h0;
        req_a       = 32'd0;
        req_b       = 32'd0;
        req_shamt   = 5'd0;
        req_use_acc = 1'b0;
        rsp_ready   = 1'b0;

        vecs[0]  = '{4'h0, 32'd19,         32'd55,         5'd0, 1'b0, 0, 1'b0, 32'd74,         1'b0};
        vecs[1]  = '{4'h0, 32'hFFFF0000,   32'd6,          5'd0, 1'b1, 0, 1'b1, 32'd80,         1'b0};
        vecs[2]  = '{4'h1, 32'd59,         32'd38,         5'd0, 1'b0, 5, 1'b1, 32'd21,         1'b0};
        vecs[3]  = '{4'h2, 32'd5,          32'd10,         5'd0, 1'b0, 0, 1'b0, 32'd1,          1'b0};
        vecs[4]  = '{4'h2, 32'd10,         32'd5,          5'd0, 1'b0, 1, 1'b0, 32'd0,          1'b0};
        vecs[5]  = '{4'h1, 32'd5,          32'd5,          5'd0, 1'b0, 0, 1'b0, 32'd0,          1'b0};
        vecs[6]  = '{4'h7, 32'd9,          32'd112,        5'd3, 1'b0, 0, 1'b0, 32'd57344,      1'b0};
        vecs[7]  = '{4'hA, 32'h00001234,   32'd456,        5'd7, 1'b0, 0, 1'b0, 32'd3,          1'b0};
        vecs[8]  = '{4'h9, 32'h0000001F,   32'hDEADBEEF,   5'd0, 1'b0, 0, 1'b0, 32'hDEADBEEF,   1'b0};
        vecs[9]  = '{4'h4, 32'd195,        32'd228,        5'd0, 1'b0, 0, 1'b0, 32'd231,        1'b0};
        vecs[10] = '{4'h3, 32'd656,        32'd218,        5'd0, 1'b0, 0, 1'b0, 32'd144,        1'b0};
        vecs[11] = '{4'h5, 32'd99,         32'd286,        5'd0, 1'b0, 0, 1'b0, 32'd381,        1'b0};
        vecs[12] = '{4'h6, 32'd77,         32'd486,        5'd0, 1'b0, 0, 1'b0, 32'hFFFFFE10,   1'b0};
        vecs[13] = '{4'h0, 32'd19,         32'd55,         5'd0, 1'b0, 0, 1'b0, 32'd74,         1'b0};
        vecs[14] = '{4'hC, 32'd1234,       32'd5678,       5'd4, 1'b0, 2, 1'b0, 32'd0,          1'b1};
        vecs[15] = '{4'h0, 32'h12345678,   32'd1,          5'd0, 1'b1, 0, 1'b0, 32'd75,         1'b0};
        vecs[16] = '{4'h8, 32'd4,          32'h80000000,   5'd9, 1'b0, 0, 1'b0, 32'h08000000,   1'b0};
        vecs[17] = '{4'hF, 32'd7,          32'd8,          5'd1, 1'b1, 0, 1'b0, 32'd0,          1'b1};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_data", rsp_data, 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        checkOutput("reset_alu_a", alu_a, 32'd0);
        checkOutput("reset_alu_b", alu_b, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].ua,
                          vecs[i].hold, vecs[i].early, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Reset while an operation sits in ISSUE: result lost, accumulator cleared.
        applyStimulus(4'h0, 32'd100, 32'd1, 5'd0, 1'b0, 0, 1'b0, 32'd101, 1'b0);
        req_valid   = 1'b1;
        req_op      = 4'h0;
        req_a       = 32'd7;
        req_b       = 32'd8;
        req_use_acc = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_issue_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_issue_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_issue_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_issue_alu_a", alu_a, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_issue_rsp_valid_2", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_issue_req_ready_after", 32'(req_ready), 32'd1);
        model_acc = 32'd0;
        applyStimulus(4'h0, 32'hCAFEF00D, 32'd5, 5'd0, 1'b1, 0, 1'b0, 32'd5, 1'b0);

        // Randomized operations checked against the opcode-level model.
        for (int i = 0; i < 60; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = $urandom;
            r_sh = 5'($urandom);
            r_ua = 1'($urandom);
            if (i % 7 == 3) begin
                r_b = r_a;
            end
            refModel(r_op, r_ua ? model_acc : r_a, r_b, r_sh, r_data, r_err);
            applyStimulus(r_op, r_a, r_b, r_sh, r_ua, $urandom_range(0, 3),
                          1'($urandom), r_data, r_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
